// File: rtl/vec_dmem_ctrl.sv
// Data-memory stage controller: single-cycle scalar word access plus 4-lane
// vector loads/stores serialised one lane per cycle onto a single-port word RAM.
module vec_dmem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  MemWriteM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    input  logic                  MemReadVecM,
    input  logic                  MemWriteVecM,
    input  logic [31:0]           VectorAddressM [0:3],
    input  logic [DATA_WIDTH-1:0] WriteDataMVec  [0:3],
    output logic [DATA_WIDTH-1:0] ReadDataVecM   [0:3],
    output logic                  MemBusyM,
    output logic                  VecDoneM
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic                    is_store_q, is_store_d;
    logic [ADDR_WIDTH-1:0]   addr_q  [0:3];
    logic [ADDR_WIDTH-1:0]   addr_d  [0:3];
    logic [DATA_WIDTH-1:0]   data_q  [0:3];
    logic [DATA_WIDTH-1:0]   data_d  [0:3];
    logic [DATA_WIDTH-1:0]   rdata_q [0:3];
    logic [DATA_WIDTH-1:0]   rdata_d [0:3];

    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [ADDR_WIDTH-1:0]   scalar_idx;
    logic [ADDR_WIDTH-1:0]   vec_idx [0:3];
    logic                    vec_req;
    logic [3:0]              vec_unused_bits;
    logic                    unused_addr_bits;

    // Byte address -> word index; offset and upper bits are dropped so accesses wrap.
    assign scalar_idx = ALUOutM[ADDR_WIDTH+1:2];
    assign vec_req    = MemReadVecM | MemWriteVecM;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign vec_idx[gi]         = VectorAddressM[gi][ADDR_WIDTH+1:2];
            assign vec_unused_bits[gi] = ^{VectorAddressM[gi][31:ADDR_WIDTH+2], VectorAddressM[gi][1:0]};
            assign ReadDataVecM[gi]    = rdata_q[gi];
        end
    endgenerate

    assign unused_addr_bits = ^{ALUOutM[31:ADDR_WIDTH+2], ALUOutM[1:0], vec_unused_bits};

    assign ReadDataM = mem_q[scalar_idx];

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        MemBusyM   = 1'b0;
        VecDoneM   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (vec_req) begin
                    // A vector request takes priority and suppresses any scalar store.
                    MemBusyM   = 1'b1;
                    is_store_d = MemWriteVecM;
                    lane_d     = 2'd0;
                    state_d    = S_XFER;
                    for (int i = 0; i < 4; i++) begin
                        addr_d[i] = vec_idx[i];
                        data_d[i] = WriteDataMVec[i];
                    end
                end else if (MemWriteM) begin
                    mem_we    = 1'b1;
                    mem_waddr = scalar_idx;
                    mem_wdata = WriteDataM;
                end
            end
            S_XFER: begin
                MemBusyM = 1'b1;
                if (is_store_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_q[lane_q];
                    mem_wdata = data_q[lane_q];
                end else begin
                    rdata_d[lane_q] = mem_q[addr_q[lane_q]];
                end
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                VecDoneM = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset behaves like IDLE for the stall output and blocks any pending lane write.
        if (reset) begin
            mem_we   = 1'b0;
            MemBusyM = vec_req;
            VecDoneM = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            is_store_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule
